// File: rtl/hdr_exposure_sequencer.sv
// HDR exposure bracketing controller: switches sensor AEC off, programs a
// low/mid/high exposure per trigger over SCCB and tags the DDR slot of each frame.
module hdr_exposure_sequencer #(
    parameter logic [15:0] EXP_LO      = 16'h0040,
    parameter logic [15:0] EXP_MID     = 16'h0100,
    parameter logic [15:0] EXP_HI      = 16'h0400,
    parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
    input  logic       p_clk,
    input  logic       rst_n,
    input  logic       hdr_en,
    input  logic       take_pic,
    input  logic       change_exp,
    input  logic       frame_done,
    input  logic [2:0] last_frame,
    input  logic       sccb_ack,
    output logic       sccb_req,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic [1:0] exp_idx,
    output logic [2:0] slot_lo,
    output logic [2:0] slot_mid,
    output logic [2:0] slot_hi,
    output logic       bracket_done,
    output logic       cfg_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_AEC_OFF    = 3'd1,
        ST_WAIT_TRIG  = 3'd2,
        ST_WR_AECHH   = 3'd3,
        ST_WR_AECH    = 3'd4,
        ST_WR_COM1    = 3'd5,
        ST_WAIT_FRAME = 3'd6,
        ST_AEC_ON     = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  slot_lo_q, slot_lo_d;
    logic [2:0]  slot_mid_q, slot_mid_d;
    logic [2:0]  slot_hi_q, slot_hi_d;
    logic        bd_q, bd_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] tmo_q, tmo_d;
    logic        off_pend_q, off_pend_d;
    logic        tp_pend_q, tp_pend_d;
    logic        off_now_s;
    logic        tp_now_s;
    logic        exp_wr_s;

    function automatic logic [15:0] exp_value(input logic [1:0] idx);
        logic [15:0] v;
        case (idx)
            2'd0:    v = EXP_LO;
            2'd1:    v = EXP_MID;
            2'd2:    v = EXP_HI;
            default: v = EXP_LO;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] wr_addr(input state_t st);
        logic [7:0] a;
        case (st)
            ST_AEC_OFF:  a = 8'h13;
            ST_AEC_ON:   a = 8'h13;
            ST_WR_AECHH: a = 8'h07;
            ST_WR_AECH:  a = 8'h10;
            ST_WR_COM1:  a = 8'h04;
            default:     a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] wr_data(input state_t st, input logic [15:0] e);
        logic [7:0] d;
        case (st)
            ST_AEC_OFF:  d = 8'hE0;
            ST_AEC_ON:   d = 8'hE7;
            ST_WR_AECHH: d = {2'b00, e[15:10]};
            ST_WR_AECH:  d = e[9:2];
            ST_WR_COM1:  d = {6'b000000, e[1:0]};
            default:     d = 8'h00;
        endcase
        return d;
    endfunction

    function automatic state_t next_after_write(input state_t st);
        state_t n;
        case (st)
            ST_AEC_OFF:  n = ST_WAIT_TRIG;
            ST_WR_AECHH: n = ST_WR_AECH;
            ST_WR_AECH:  n = ST_WR_COM1;
            ST_WR_COM1:  n = ST_WAIT_FRAME;
            ST_AEC_ON:   n = ST_IDLE;
            default:     n = ST_IDLE;
        endcase
        return n;
    endfunction

    // Shutdown or restart requests stay pending until any in-flight SCCB write ends.
    assign off_now_s = off_pend_q | ~hdr_en;
    assign tp_now_s  = tp_pend_q | take_pic;
    assign exp_wr_s  = (state_q == ST_WR_AECHH) || (state_q == ST_WR_AECH) ||
                       (state_q == ST_WR_COM1);

    // Next-state, SCCB handshake, slot tagging and bracket bookkeeping.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        slot_lo_d  = slot_lo_q;
        slot_mid_d = slot_mid_q;
        slot_hi_d  = slot_hi_q;
        bd_d       = 1'b0;
        err_d      = err_q;
        tmo_d      = 16'd0;
        off_pend_d = off_pend_q;
        tp_pend_d  = tp_pend_q;

        if (take_pic) begin
            idx_d      = 2'd0;
            slot_lo_d  = 3'd0;
            slot_mid_d = 3'd0;
            slot_hi_d  = 3'd0;
            if (exp_wr_s || (state_q == ST_AEC_OFF)) begin
                tp_pend_d = 1'b1;
            end else begin
                tp_pend_d = tp_pend_q;
            end
        end else begin
            tp_pend_d = tp_pend_q;
        end

        if (!hdr_en && (state_q != ST_IDLE) && (state_q != ST_AEC_ON)) begin
            idx_d      = 2'd0;
            off_pend_d = 1'b1;
        end else begin
            off_pend_d = off_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (hdr_en) begin
                    state_d = ST_AEC_OFF;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_TRIG: begin
                if (off_now_s) begin
                    state_d = ST_AEC_ON;
                end else if (take_pic) begin
                    state_d = ST_WAIT_TRIG;
                end else if (change_exp) begin
                    state_d = ST_WR_AECHH;
                end else begin
                    state_d = ST_WAIT_TRIG;
                end
            end

            ST_WAIT_FRAME: begin
                if (off_now_s) begin
                    state_d = ST_AEC_ON;
                end else if (take_pic) begin
                    state_d = ST_WAIT_TRIG;
                end else if (frame_done) begin
                    case (idx_q)
                        2'd0:    slot_lo_d  = last_frame;
                        2'd1:    slot_mid_d = last_frame;
                        2'd2:    slot_hi_d  = last_frame;
                        default: slot_lo_d  = slot_lo_q;
                    endcase
                    if (idx_q == 2'd2) begin
                        bd_d  = 1'b1;
                        idx_d = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                    state_d = ST_WAIT_TRIG;
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end

            ST_AEC_OFF, ST_WR_AECHH, ST_WR_AECH, ST_WR_COM1, ST_AEC_ON: begin
                // req_q low here means the write has not been issued yet, so an
                // abort can skip it; this also guarantees a req-low gap between writes.
                if (!req_q) begin
                    if ((state_q != ST_AEC_ON) && off_now_s) begin
                        state_d = ST_AEC_ON;
                    end else if (exp_wr_s && tp_now_s) begin
                        state_d = ST_WAIT_TRIG;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = wr_addr(state_q);
                        data_d = wr_data(state_q, exp_value(idx_q));
                    end
                end else if (sccb_ack) begin
                    req_d = 1'b0;
                    if (state_q == ST_AEC_ON) begin
                        state_d = ST_IDLE;
                    end else if (off_now_s) begin
                        state_d = ST_AEC_ON;
                    end else if (tp_now_s) begin
                        state_d = ST_WAIT_TRIG;
                    end else begin
                        state_d = next_after_write(state_q);
                    end
                end else if (tmo_q == (ACK_TIMEOUT - 16'd1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if ((state_d == ST_IDLE) || (state_d == ST_AEC_ON)) begin
            off_pend_d = 1'b0;
        end else begin
            off_pend_d = off_pend_d;
        end
        if ((state_d == ST_IDLE) || (state_d == ST_WAIT_TRIG)) begin
            tp_pend_d = 1'b0;
        end else begin
            tp_pend_d = tp_pend_d;
        end

        busy_d = !((state_d == ST_IDLE) || (state_d == ST_WAIT_TRIG));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge p_clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            idx_q      <= 2'd0;
            slot_lo_q  <= 3'd0;
            slot_mid_q <= 3'd0;
            slot_hi_q  <= 3'd0;
            bd_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 16'd0;
            off_pend_q <= 1'b0;
            tp_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            slot_lo_q  <= slot_lo_d;
            slot_mid_q <= slot_mid_d;
            slot_hi_q  <= slot_hi_d;
            bd_q       <= bd_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            off_pend_q <= off_pend_d;
            tp_pend_q  <= tp_pend_d;
        end
    end

    assign sccb_req     = req_q;
    assign sccb_addr    = addr_q;
    assign sccb_data    = data_q;
    assign exp_idx      = idx_q;
    assign slot_lo      = slot_lo_q;
    assign slot_mid     = slot_mid_q;
    assign slot_hi      = slot_hi_q;
    assign bracket_done = bd_q;
    assign cfg_error    = err_q;
    assign busy         = busy_q;

endmodule

// File: doc/hdr_exposure_sequencer.md
Name: hdr_exposure_sequencer

Overview:
Controller that brackets camera exposure for HDR capture. It disables sensor auto-exposure and, on each change_exp pulse from the capture block, programs the next exposure from a fixed table through an SCCB write-request handshake. It records which DDR frame slot (last_frame) holds each exposure and pulses bracket_done once a full low/mid/high set has been captured. It sits between camera capture, the SCCB master and the HDR merge/reader logic.

Parameters:
EXP_LO, 16'h0040, exposure value (rows) for bracket index 0
EXP_MID, 16'h0100, exposure value for index 1
EXP_HI, 16'h0400, exposure value for index 2
ACK_TIMEOUT, 16'd50000, max p_clk cycles between sccb_req rise and sccb_ack

Ports:
p_clk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
hdr_en  in  1  level; 1 = run bracketing, 0 = restore auto-exposure and idle
take_pic  in  1  level/pulse; restart bracket at index 0, clear slot tags
change_exp  in  1  1-cycle pulse from capture, row 480 of current frame
frame_done  in  1  1-cycle pulse from capture, vsync falling edge
last_frame  in  3  frame slot 0..5 from capture, sampled on frame_done
sccb_ack  in  1  1-cycle pulse: SCCB master finished current write
sccb_req  out  1  write request, held until ack
sccb_addr  out  8  sensor register address, stable while sccb_req=1
sccb_data  out  8  register data, stable while sccb_req=1
exp_idx  out  2  exposure index currently programmed/being captured (0..2)
slot_lo  out  3  frame slot holding index-0 frame
slot_mid  out  3  frame slot holding index-1 frame
slot_hi  out  3  frame slot holding index-2 frame
bracket_done  out  1  1-cycle pulse, slot_* valid for a complete bracket
cfg_error  out  1  sticky: ack timeout occurred
busy  out  1  1 when state is not IDLE or WAIT_TRIG

Behaviour:
- Reset (rst_n=0 at edge): all outputs 0, state IDLE, timeout counter 0; sccb_req drops immediately even mid-transaction.
- States: IDLE, AEC_OFF, WAIT_TRIG, WR_AECHH, WR_AECH, WR_COM1, WAIT_FRAME, AEC_ON.
- IDLE: hdr_en=1 -> AEC_OFF.
- AEC_OFF: write addr 8'h13 data 8'hE0 (AEC/AGC off) -> WAIT_TRIG.
- WAIT_TRIG: change_exp=1 -> WR_AECHH using table[exp_idx].
- Writes for exposure E: WR_AECHH addr 8'h07 data {2'b00,E[15:10]}; WR_AECH addr 8'h10 data E[9:2]; WR_COM1 addr 8'h04 data {6'b0,E[1:0]}; then WAIT_FRAME.
- Handshake: in each write state sccb_req=1 with addr/data set from the state entry cycle; on the cycle sccb_ack=1 is sampled, sccb_req deasserts next edge and the state advances. Minimum one req-low cycle between consecutive writes. sccb_ack while sccb_req=0 is ignored.
- Timeout: counter counts cycles with sccb_req=1; reaching ACK_TIMEOUT -> cfg_error<=1 (sticky until reset), sccb_req<=0, state IDLE. Because hdr_en is level, IDLE re-enters AEC_OFF the next cycle if hdr_en=1.
- WAIT_FRAME: on frame_done, tag slot_{exp_idx} <= last_frame (value sampled that cycle). If exp_idx=2: bracket_done=1 next cycle and exp_idx wraps to 0. Otherwise exp_idx+1. Then -> WAIT_TRIG.
- slot_* outputs change only on a tag write; they hold their last values otherwise.
- change_exp outside WAIT_TRIG is ignored (no queuing). frame_done outside WAIT_FRAME is ignored (frame not tagged).
- change_exp and frame_done in the same cycle in WAIT_FRAME: frame_done is processed and change_exp is dropped.
- hdr_en=0 in any state other than IDLE/AEC_ON: an in-flight write completes (or times out), then AEC_ON writes addr 8'h13 data 8'hE7, then IDLE. exp_idx <= 0. slot_* hold.
- take_pic=1: exp_idx<=0 and slot_* <=0 on that edge. An in-flight write completes, then the state goes to WAIT_TRIG. Any pending bracket_done is suppressed. take_pic takes priority over a same-cycle frame_done tag.
- bracket_done is never asserted more than 1 cycle, and never on reset exit.

Test Plan:
- Reset, hdr_en=1, ack 3 cycles after each req -> exactly one write (8'h13, 8'hE0), busy=0 in WAIT_TRIG.
- change_exp pulse at idx 0 -> writes (07,00),(10,10),(04,00) in order, each req held until ack; frame_done with last_frame=2 -> slot_lo=2, exp_idx=1.
- Three triggers and frame_dones with last_frame=3,4,5 -> slot_lo=3, slot_mid=4, slot_hi=5, bracket_done high exactly 1 cycle, exp_idx=0. Idx 2 writes are (07,01),(10,00),(04,00).
- Withhold sccb_ack for ACK_TIMEOUT cycles during WR_AECH -> cfg_error=1, sccb_req=0, state returns through IDLE to AEC_OFF; cfg_error stays 1.
- Drop hdr_en mid-WR_AECHH -> current write completes on ack, then (13,E7) write, then idle with exp_idx=0. frame_done during writes does not change slot_*.
- take_pic during WAIT_FRAME at idx 2, concurrent with frame_done -> no bracket_done, slot_* =0, exp_idx=0, state WAIT_TRIG.
